// File: rtl/cpu_pkg.sv
// Shared definitions for the cpu_core pipeline: encodings, ALU operations,
// pipeline-register layouts and the instruction decoder.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [1:0] {ALU_ADD, ALU_SUB, ALU_SLT} alu_op_t;

  // src1/src2 are zero when the operand is not read, so R0 never creates a hazard
  typedef struct packed {
    alu_op_t    alu_op;
    logic       use_imm;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic [4:0] dest;
    logic [4:0] src1;
    logic [4:0] src2;
  } ctrl_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        use_imm;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] imm;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] store_data;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic [4:0]  dest;
    logic [31:0] result;
  } mem_wb_t;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  function automatic logic [31:0] alu(input alu_op_t op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      ALU_SUB: return a - b;
      ALU_SLT: return {31'd0, ($signed(a) < $signed(b))};
      default: return a + b;
    endcase
  endfunction

  function automatic ctrl_t decode(input logic [31:0] instr);
    ctrl_t c;
    c = '0;
    case (instr[31:26])
      OP_ADDI: begin
        c.use_imm = 1'b1; c.reg_write = 1'b1;
        c.dest = instr[20:16]; c.src1 = instr[25:21];
      end
      OP_LW: begin
        c.use_imm = 1'b1; c.reg_write = 1'b1; c.mem_read = 1'b1;
        c.dest = instr[20:16]; c.src1 = instr[25:21];
      end
      OP_SW: begin
        c.use_imm = 1'b1; c.mem_write = 1'b1;
        c.src1 = instr[25:21]; c.src2 = instr[20:16];
      end
      OP_RTYPE: begin
        c.reg_write = 1'b1; c.dest = instr[15:11];
        c.src1 = instr[25:21]; c.src2 = instr[20:16];
        case (instr[5:0])
          FN_ADD:  c.alu_op = ALU_ADD;
          FN_SUB:  c.alu_op = ALU_SUB;
          FN_SLT:  c.alu_op = ALU_SLT;
          default: c = '0;
        endcase
      end
      default: c = '0;
    endcase
    if (c.dest == 5'd0) c.reg_write = 1'b0;
    return c;
  endfunction

endpackage

// File: rtl/cpu_regfile.sv
// 32 x 32 register file: two combinational read ports with write-through
// from the single write port; R0 always reads zero.
module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1,
  output logic [31:0] rdata2
);

  logic [31:0] regs [32];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && waddr != 5'd0) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = regs[raddr1];
    if (we && waddr == raddr1) rdata1 = wdata;
    if (raddr1 == 5'd0) rdata1 = '0;
  end

  always_comb begin
    rdata2 = regs[raddr2];
    if (we && waddr == raddr2) rdata2 = wdata;
    if (raddr2 == 5'd0) rdata2 = '0;
  end

endmodule

// File: rtl/cpu_core.sv
// Five-stage (IF/ID/EX/MEM/WB) pipelined core with instruction load mode.
// Define CPU_FORWARD_EN for EX operand forwarding; otherwise ID stalls on RAW hazards.
module cpu_core import cpu_pkg::*; #(
  parameter int IMEM_DEPTH = 64,
  parameter int DMEM_DEPTH = 64
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        LoadInstructions,
  input  logic [31:0] Instruction,
  output logic [31:0] out
);

  localparam int IA = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
  localparam int DA = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

  logic [31:0]   imem [IMEM_DEPTH];
  logic [31:0]   dmem [DMEM_DEPTH];
  logic [IA-1:0] pc_reg, load_ptr_reg;
  logic [31:0]   if_id_reg;
  id_ex_t        id_ex_reg, id_ex_next;
  ex_mem_t       ex_mem_reg, ex_mem_next;
  mem_wb_t       mem_wb_reg, mem_wb_next;
  ctrl_t         id_ctrl;
  logic [31:0]   rf_a, rf_b, ex_a, ex_b;
  logic [DA-1:0] mem_addr;
  logic          stall;

  function automatic logic [IA-1:0] ptr_inc(input logic [IA-1:0] p);
    return (p == IA'(IMEM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic reads(input ctrl_t c, input logic [4:0] r);
    return (c.src1 == r) || (c.src2 == r);
  endfunction

  assign id_ctrl = decode(if_id_reg);

  cpu_regfile u_regfile (
    .clk    (clk),
    .rst    (Reset),
    .we     (!LoadInstructions && mem_wb_reg.reg_write),
    .waddr  (mem_wb_reg.dest),
    .wdata  (mem_wb_reg.result),
    .raddr1 (if_id_reg[25:21]),
    .raddr2 (if_id_reg[20:16]),
    .rdata1 (rf_a),
    .rdata2 (rf_b)
  );

  always_comb begin
`ifdef CPU_FORWARD_EN
    stall = id_ex_reg.mem_read && id_ex_reg.reg_write && reads(id_ctrl, id_ex_reg.dest);
`else
    // a producer in WB is covered by the register file write-through
    stall = (id_ex_reg.reg_write && reads(id_ctrl, id_ex_reg.dest)) ||
            (ex_mem_reg.reg_write && reads(id_ctrl, ex_mem_reg.dest));
`endif
  end

  always_comb begin
    id_ex_next           = '0;
    id_ex_next.alu_op    = id_ctrl.alu_op;
    id_ex_next.use_imm   = id_ctrl.use_imm;
    id_ex_next.mem_read  = id_ctrl.mem_read;
    id_ex_next.mem_write = id_ctrl.mem_write;
    id_ex_next.reg_write = id_ctrl.reg_write;
    id_ex_next.dest      = id_ctrl.dest;
    id_ex_next.a         = rf_a;
    id_ex_next.b         = rf_b;
    id_ex_next.imm       = sext16(if_id_reg[15:0]);
  end

`ifdef CPU_FORWARD_EN
  logic [4:0] ex_src1_reg, ex_src2_reg;

  // the younger producer (EX/MEM) wins over MEM/WB
  always_comb begin
    ex_a = id_ex_reg.a;
    ex_b = id_ex_reg.b;
    if (mem_wb_reg.reg_write && mem_wb_reg.dest == ex_src1_reg) ex_a = mem_wb_reg.result;
    if (ex_mem_reg.reg_write && ex_mem_reg.dest == ex_src1_reg) ex_a = ex_mem_reg.alu_result;
    if (mem_wb_reg.reg_write && mem_wb_reg.dest == ex_src2_reg) ex_b = mem_wb_reg.result;
    if (ex_mem_reg.reg_write && ex_mem_reg.dest == ex_src2_reg) ex_b = ex_mem_reg.alu_result;
  end
`else
  assign ex_a = id_ex_reg.a;
  assign ex_b = id_ex_reg.b;
`endif

  always_comb begin
    ex_mem_next            = '0;
    ex_mem_next.reg_write  = id_ex_reg.reg_write;
    ex_mem_next.mem_read   = id_ex_reg.mem_read;
    ex_mem_next.mem_write  = id_ex_reg.mem_write;
    ex_mem_next.dest       = id_ex_reg.dest;
    ex_mem_next.alu_result = alu(id_ex_reg.alu_op, ex_a, id_ex_reg.use_imm ? id_ex_reg.imm : ex_b);
    ex_mem_next.store_data = ex_b;
  end

  assign mem_addr = ex_mem_reg.alu_result[DA-1:0];

  always_comb begin
    mem_wb_next           = '0;
    mem_wb_next.reg_write = ex_mem_reg.reg_write;
    mem_wb_next.dest      = ex_mem_reg.dest;
    mem_wb_next.result    = ex_mem_reg.mem_read ? dmem[mem_addr] : ex_mem_reg.alu_result;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      pc_reg       <= '0;
      load_ptr_reg <= '0;
      if_id_reg    <= '0;
      id_ex_reg    <= '0;
      ex_mem_reg   <= '0;
      mem_wb_reg   <= '0;
      out          <= '0;
`ifdef CPU_FORWARD_EN
      ex_src1_reg  <= '0;
      ex_src2_reg  <= '0;
`endif
    end else if (LoadInstructions) begin
      load_ptr_reg <= ptr_inc(load_ptr_reg);
    end else begin
      if (stall) begin
        id_ex_reg <= '0;
`ifdef CPU_FORWARD_EN
        ex_src1_reg <= '0;
        ex_src2_reg <= '0;
`endif
      end else begin
        pc_reg    <= ptr_inc(pc_reg);
        if_id_reg <= imem[pc_reg];
        id_ex_reg <= id_ex_next;
`ifdef CPU_FORWARD_EN
        ex_src1_reg <= id_ctrl.src1;
        ex_src2_reg <= id_ctrl.src2;
`endif
      end
      ex_mem_reg <= ex_mem_next;
      mem_wb_reg <= mem_wb_next;
      if (mem_wb_reg.reg_write) out <= mem_wb_reg.result;
    end
  end

  // instruction memory survives reset
  always_ff @(posedge clk) begin
    if (!Reset && LoadInstructions) imem[load_ptr_reg] <= Instruction;
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DMEM_DEPTH; i++) dmem[i] <= 32'(i);
    end else if (!LoadInstructions && ex_mem_reg.mem_write) begin
      dmem[mem_addr] <= ex_mem_reg.store_data;
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// Self-checking bench for cpu_core: directed program, load freeze, mid-run
// reset and random programs against an instruction-level reference model.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        Reset;
  logic        LoadInstructions;
  logic [31:0] Instruction;
  logic [31:0] out;

  always #5 clk = ~clk;

  cpu_core dut (
    .clk              (clk),
    .Reset            (Reset),
    .LoadInstructions (LoadInstructions),
    .Instruction      (Instruction),
    .out              (out)
  );

  int checks = 0;
  int passes = 0;

  logic [31:0] prog  [64];
  int          prog_len;
  logic [31:0] trace [128];
  int          tcyc;
  logic [31:0] obs_v[$];
  int          obs_c[$];
  logic [31:0] m_regs [32];
  logic [31:0] m_dmem [64];
  logic [31:0] m_seq[$];

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rt,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  function automatic logic [31:0] sx(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

  // instruction-by-instruction execution of prog[0..prog_len-1]
  task automatic model_run();
    logic [31:0] w, v, prev;
    logic [5:0]  addr;
    logic        wr;
    logic [4:0]  dst;
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    for (int i = 0; i < 64; i++) m_dmem[i] = i;
    m_seq.delete();
    prev = 0;
    for (int p = 0; p < prog_len; p++) begin
      w = prog[p]; wr = 0; dst = 0; v = 0;
      addr = 6'(m_regs[w[25:21]] + sx(w[15:0]));
      case (w[31:26])
        6'h08: begin wr = 1; dst = w[20:16]; v = m_regs[w[25:21]] + sx(w[15:0]); end
        6'h23: begin wr = 1; dst = w[20:16]; v = m_dmem[addr]; end
        6'h2B: m_dmem[addr] = m_regs[w[20:16]];
        6'h00: begin
          dst = w[15:11];
          if (w[5:0] == 6'h20) begin wr = 1; v = m_regs[w[25:21]] + m_regs[w[20:16]]; end
          if (w[5:0] == 6'h22) begin wr = 1; v = m_regs[w[25:21]] - m_regs[w[20:16]]; end
          if (w[5:0] == 6'h2A) begin
            wr = 1;
            v = ($signed(m_regs[w[25:21]]) < $signed(m_regs[w[20:16]])) ? 1 : 0;
          end
        end
        default: ;
      endcase
      if (wr && dst != 0) begin
        m_regs[dst] = v;
        if (v != prev) m_seq.push_back(v);
        prev = v;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic load_and_reset();
    LoadInstructions = 1; Reset = 1;
    tick();
    Reset = 0;
    for (int i = 0; i < 64; i++) begin
      Instruction = prog[i];
      tick();
    end
    Reset = 1; #2;
    LoadInstructions = 0; Instruction = 0;
    tick();
    Reset = 0; tcyc = 0; trace[0] = out;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      if (tcyc < 127) tcyc++;
      trace[tcyc] = out;
    end
  endtask

  task automatic collect();
    logic [31:0] prev;
    obs_v.delete(); obs_c.delete();
    prev = 0;
    for (int c = 1; c <= tcyc; c++) begin
      if (trace[c] !== prev) begin
        obs_v.push_back(trace[c]); obs_c.push_back(c);
        prev = trace[c];
      end
    end
  endtask

  task automatic build_directed();
    for (int i = 0; i < 64; i++) prog[i] = 0;
    prog[0]  = enc_i(6'h08, 1, 0, 16'd423);
    prog[1]  = enc_i(6'h08, 2, 0, 16'd92);
    prog[2]  = enc_i(6'h08, 3, 0, 16'd13);
    prog[3]  = enc_i(6'h08, 4, 0, 16'd146);
    prog[4]  = enc_i(6'h08, 5, 0, 16'd5);
    prog[5]  = enc_r(6'h20, 5, 1, 4);
    prog[6]  = enc_r(6'h2A, 6, 3, 5);
    prog[7]  = enc_i(6'h23, 4, 0, 16'd4);
    prog[8]  = enc_r(6'h22, 7, 4, 6);
    prog[9]  = enc_i(6'h2B, 7, 0, 16'd0);
    prog[10] = enc_r(6'h20, 8, 7, 2);
    prog[11] = enc_i(6'h08, 0, 1, 16'd15);
    prog[12] = enc_i(6'h08, 20, 0, 16'd15);
    prog[13] = enc_i(6'h08, 4, 4, 16'd10);
    prog_len = 14;
  endtask

  task automatic test_reset();
    Reset = 1; LoadInstructions = 0; Instruction = 0;
    #12;
    checks++; if (out !== 32'd0) $display("FAIL reset_out: got %0d expected 0", out); else passes++;
    checks++; if (dut.pc_reg !== 6'd0) $display("FAIL reset_pc: got %0d expected 0", dut.pc_reg); else passes++;
    checks++; if (dut.load_ptr_reg !== 6'd0) $display("FAIL reset_load_ptr: got %0d expected 0", dut.load_ptr_reg); else passes++;
    checks++; if (dut.dmem[9] !== 32'd9) $display("FAIL reset_dmem9: got %0d expected 9", dut.dmem[9]); else passes++;
    checks++; if (dut.u_regfile.regs[5] !== 32'd0) $display("FAIL reset_r5: got %0d expected 0", dut.u_regfile.regs[5]); else passes++;
  endtask

  task automatic test_directed();
    logic [31:0] exp_seq [12] = '{423, 92, 13, 146, 5, 569, 1, 4, 3, 95, 15, 14};
    int exp_regs [9] = '{423, 92, 13, 14, 569, 1, 3, 95, 15};
    int reg_ids  [9] = '{1, 2, 3, 4, 5, 6, 7, 8, 20};
    int gap_slt, gap_sub;
`ifdef CPU_FORWARD_EN
    gap_slt = 1; gap_sub = 2;
`else
    gap_slt = 3; gap_sub = 3;
`endif
    build_directed();
    load_and_reset();
    run(40);
    collect();
    checks++; if (trace[4] !== 32'd0) $display("FAIL latency_before: got %0d expected 0", trace[4]); else passes++;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (trace[5+k] !== exp_seq[k]) $display("FAIL addi_cycle%0d: got %0d expected %0d", 5+k, trace[5+k], exp_seq[k]);
      else passes++;
    end
    checks++; if (obs_v.size() != 12) $display("FAIL dir_seq_len: got %0d expected 12", obs_v.size()); else passes++;
    for (int k = 0; k < 12 && k < obs_v.size(); k++) begin
      checks++;
      if (obs_v[k] !== exp_seq[k]) $display("FAIL dir_seq%0d: got %0d expected %0d", k, obs_v[k], exp_seq[k]);
      else passes++;
    end
    if (obs_c.size() == 12) begin
      checks++;
      if (obs_c[6] - obs_c[5] != gap_slt) $display("FAIL gap_slt: got %0d expected %0d", obs_c[6] - obs_c[5], gap_slt);
      else passes++;
      checks++;
      if (obs_c[8] - obs_c[7] != gap_sub) $display("FAIL gap_sub: got %0d expected %0d", obs_c[8] - obs_c[7], gap_sub);
      else passes++;
    end
    for (int k = 0; k < 9; k++) begin
      checks++;
      if (dut.u_regfile.regs[reg_ids[k]] !== 32'(exp_regs[k]))
        $display("FAIL dir_r%0d: got %0d expected %0d", reg_ids[k], dut.u_regfile.regs[reg_ids[k]], exp_regs[k]);
      else passes++;
    end
    checks++; if (dut.u_regfile.rdata1 !== dut.u_regfile.rdata1 || dut.u_regfile.regs[0] !== 32'd0)
      $display("FAIL dir_r0: got %0d expected 0", dut.u_regfile.regs[0]); else passes++;
    checks++; if (dut.dmem[0] !== 32'd3) $display("FAIL dir_dmem0: got %0d expected 3", dut.dmem[0]); else passes++;
  endtask

  task automatic test_load_freeze();
    Reset = 1; tick(); Reset = 0; tcyc = 0;
    run(2);
    LoadInstructions = 1;
    for (int i = 0; i < 3; i++) begin
      Instruction = prog[i];
      tick();
      checks++; if (out !== 32'd0) $display("FAIL freeze_out%0d: got %0d expected 0", i, out); else passes++;
      checks++; if (dut.pc_reg !== 6'd2) $display("FAIL freeze_pc%0d: got %0d expected 2", i, dut.pc_reg); else passes++;
    end
    LoadInstructions = 0; Instruction = 0;
    run(3);
    checks++; if (trace[4] !== 32'd0) $display("FAIL freeze_lat4: got %0d expected 0", trace[4]); else passes++;
    checks++; if (trace[5] !== 32'd423) $display("FAIL freeze_lat5: got %0d expected 423", trace[5]); else passes++;
  endtask

  task automatic test_reset_mid_run();
    run(4);
    Reset = 1; #1;
    checks++; if (out !== 32'd0) $display("FAIL midreset_out: got %0d expected 0", out); else passes++;
    checks++; if (dut.pc_reg !== 6'd0) $display("FAIL midreset_pc: got %0d expected 0", dut.pc_reg); else passes++;
    checks++; if (dut.u_regfile.regs[1] !== 32'd0) $display("FAIL midreset_r1: got %0d expected 0", dut.u_regfile.regs[1]); else passes++;
    tick();
    Reset = 0; tcyc = 0; trace[0] = out;
    run(40);
    collect();
    model_run();
    checks++; if (trace[5] !== 32'd423) $display("FAIL restart_first: got %0d expected 423", trace[5]); else passes++;
    checks++; if (obs_v.size() != m_seq.size()) $display("FAIL restart_len: got %0d expected %0d", obs_v.size(), m_seq.size()); else passes++;
    for (int k = 0; k < obs_v.size() && k < m_seq.size(); k++) begin
      checks++;
      if (obs_v[k] !== m_seq[k]) $display("FAIL restart_seq%0d: got %0d expected %0d", k, obs_v[k], m_seq[k]);
      else passes++;
    end
  endtask

  task automatic test_random();
    int kind;
    logic [4:0] a, b, c;
    int bad;
    for (int it = 0; it < 3; it++) begin
      for (int i = 0; i < 64; i++) prog[i] = 0;
      prog_len = 14;
      for (int i = 0; i < prog_len; i++) begin
        kind = $urandom_range(0, 6);
        a = 5'($urandom_range(0, 7)); b = 5'($urandom_range(0, 7)); c = 5'($urandom_range(0, 7));
        case (kind)
          0: prog[i] = enc_i(6'h08, a, b, 16'($urandom));
          1: prog[i] = enc_i(6'h23, a, b, 16'($urandom_range(0, 63)));
          2: prog[i] = enc_i(6'h2B, a, b, 16'($urandom_range(0, 63)));
          3: prog[i] = enc_r(6'h20, a, b, c);
          4: prog[i] = enc_r(6'h22, a, b, c);
          5: prog[i] = enc_r(6'h2A, a, b, c);
          default: prog[i] = ($urandom_range(0, 1) == 0) ? enc_r(6'h21, a, b, c) : {6'h3F, 26'($urandom)};
        endcase
      end
      load_and_reset();
      run(56);
      collect();
      model_run();
      checks++;
      if (obs_v.size() != m_seq.size()) $display("FAIL rand%0d_len: got %0d expected %0d", it, obs_v.size(), m_seq.size());
      else passes++;
      for (int k = 0; k < obs_v.size() && k < m_seq.size(); k++) begin
        checks++;
        if (obs_v[k] !== m_seq[k]) $display("FAIL rand%0d_seq%0d: got %0d expected %0d", it, k, obs_v[k], m_seq[k]);
        else passes++;
      end
      for (int r = 1; r < 8; r++) begin
        checks++;
        if (dut.u_regfile.regs[r] !== m_regs[r])
          $display("FAIL rand%0d_r%0d: got %0d expected %0d", it, r, dut.u_regfile.regs[r], m_regs[r]);
        else passes++;
      end
      bad = -1;
      for (int d = 0; d < 64; d++) if (bad < 0 && dut.dmem[d] !== m_dmem[d]) bad = d;
      checks++;
      if (bad >= 0) $display("FAIL rand%0d_dmem%0d: got %0d expected %0d", it, bad, dut.dmem[bad], m_dmem[bad]);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_load_freeze();
    test_reset_mid_run();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: CPU

Interface
REQ-001 Parameter IMEM_DEPTH, default 64, instruction memory depth in 32-bit words.
REQ-002 Parameter DMEM_DEPTH, default 64, data memory depth in 32-bit words.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 LoadInstructions  input  1  high = instruction load mode, pipeline frozen.
REQ-006 Instruction  input  32  instruction word written in load mode.
REQ-007 out  output  32  last value written back to the register file.

Function
REQ-008 Load mode (LoadInstructions=1, Reset=0) SHALL, on each rising edge, write Instruction to imem[load_ptr], increment load_ptr (wraps at IMEM_DEPTH), and hold PC, pipeline registers, register file and data memory.
REQ-009 Run mode (LoadInstructions=0) SHALL execute a 5-stage pipeline (IF, ID, EX, MEM, WB), fetching imem[PC] and incrementing the word-indexed PC by 1 per unstalled cycle, wrapping at IMEM_DEPTH.
REQ-010 Supported ops: addi (op 0x08), lw (0x23), sw (0x2B); R-type (op 0x00) add (funct 0x20), sub (0x22), slt (0x2A, signed, result 1/0).
REQ-011 Any other encoding, including unloaded all-zero words, SHALL execute as a NOP with no register or memory write.
REQ-012 I-type immediates SHALL be sign-extended to 32 bits; add/sub/addi SHALL wrap modulo 2^32 with no overflow trap.
REQ-013 lw/sw effective address = rs + imm, used directly as word index, low log2(DMEM_DEPTH) bits only.
REQ-014 Register file: 32 x 32; writes to R0 SHALL be discarded and R0 SHALL read 0.
REQ-015 A WB-stage write and an ID-stage read of the same register in one cycle SHALL return the new value (write-through).
REQ-016 Load-use hazard (lw followed immediately by a dependent instruction) SHALL stall IF/ID one cycle and insert a bubble into EX.
REQ-017 out SHALL update on the edge an instruction with a register write to rd/rt != 0 completes WB, taking the written value.
REQ-018 out SHALL hold its value for sw, NOPs, bubbles and writes to R0.
REQ-019 Latency: an instruction fetched in cycle k SHALL reach out at the end of cycle k+4, plus any stall cycles.

Reset
REQ-020 Reset SHALL clear PC, load_ptr, all pipeline registers (to NOP), all registers and out to 0, and SHALL set dmem[i]=i for all i.
REQ-021 Reset SHALL NOT alter imem contents.
REQ-022 Reset asserted mid-execution SHALL abort in-flight instructions; after release, execution restarts at imem[0].

Configuration
REQ-023 Macro CPU_FORWARD_EN defined: EX/MEM->EX and MEM/WB->EX operand forwarding, plus the REQ-016 stall only.
REQ-024 CPU_FORWARD_EN undefined: no forwarding; ID SHALL stall while any RAW source register is pending in EX or MEM, relying on REQ-015.
REQ-025 Both builds SHALL produce identical architectural results and out value sequence; only cycle timing differs.

Structure
REQ-026 Package cpu_pkg SHALL hold opcode/funct constants, the ALU-op enum and the pipeline-register struct typedefs.
REQ-027 The register file SHALL be a sub-module cpu_regfile (2 read ports, 1 write port, write-through, R0 hardwired).

Verification
REQ-028 Load addi R1,R0,423; addi R2,R0,92; addi R3,R0,13; addi R4,R0,146; addi R5,R0,5; reset; run -> out shows 423,92,13,146,5.
REQ-029 Then add R5,R1,R4; slt R6,R3,R5 -> out 569 then 1, proving back-to-back forwarding.
REQ-030 Then lw R4,4(R0); sub R7,R4,R6 -> out 4 then 3, with one stall cycle.
REQ-031 Then sw R7,0(R0); add R8,R7,R2 -> out holds 3 during sw, then 95; dmem[0]=3.
REQ-032 Then addi R0,R1,15; addi R20,R0,15; addi R4,R4,10 -> R0 stays 0, out holds 95, then shows 15, then 14.
REQ-033 Run the whole program in both CPU_FORWARD_EN builds -> same final R1..R8, R20 and dmem[0]; assert Reset mid-run -> out=0 and execution restarts at imem[0].
